dac_dual_tx: RTL

- Dual-channel 125 MSPS DAC transmit engine; the output-side counterpart of the 12-bit dual-channel ADC capture interface in the shell.
- Accepts paired two's-complement samples over a valid/ready stream into a small FIFO.
- Sequences DAC power-up, primes the FIFO, then drives one offset-binary sample pair per clock onto the DAC data buses.
- Parks the outputs at mid-scale and flags underrun when the stream starves.

---
 rtl/dac_dual_tx_if.sv | 15 +
 rtl/dac_dual_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dac_dual_tx_if.sv
// Sample-pair stream between a producer and the dual DAC transmit engine.
// Latency: none, wires only.
// Backpressure: s_ready from the slave qualifies s_valid from the master.
// Ports: s_valid, s_ready, s_data_a, s_data_b (two's complement, DATA_W bits).
interface dac_dual_tx_if #(
  parameter int DATA_W = 12
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data_a;
  logic [DATA_W-1:0] s_data_b;

  modport master (output s_valid, output s_data_a, output s_data_b, input s_ready);
  modport slave  (input s_valid, input s_data_a, input s_data_b, output s_ready);
endinterface

// File: rtl/dac_dual_tx.sv
// Dual-channel DAC transmit engine: FIFO-buffered sample pairs, power-up sequencing, offset-binary output.
// Latency: one edge from FIFO pop to da_data/db_data; RUN entered one edge after fill reaches PRIME_LEVEL.
// Backpressure: s_ready low when disabled, OFF or FIFO full; starvation in RUN parks outputs at mid-scale.
// Ports: da_clk/reset (async, active high), enable, clr_status, s (stream slave), test_mode,
//        da_data/db_data (registered codes), pwr, running, underrun (sticky), fifo_level.
// Optional ramp generator built when DAC_RAMP_TEST_EN is defined; otherwise test_mode is ignored.
module dac_dual_tx #(
  parameter int DATA_W       = 12,
  parameter int FIFO_AW      = 4,
  parameter int PRIME_LEVEL  = 8,
  parameter int PWRUP_CYCLES = 256
) (
  input  logic               da_clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clr_status,
  dac_dual_tx_if.slave       s,
  input  logic               test_mode,
  output logic [DATA_W-1:0]  da_data,
  output logic [DATA_W-1:0]  db_data,
  output logic               pwr,
  output logic               running,
  output logic               underrun,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PTR_W = FIFO_AW + 1;
  localparam int CNT_W = $clog2(PWRUP_CYCLES + 1);
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_OFF, ST_PWRUP, ST_PRIME, ST_RUN} state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [2*DATA_W-1:0] rd_dat;
  logic [DATA_W-1:0]  da_q, db_q, da_nxt, db_nxt;
  logic [DATA_W-1:0]  ramp_da, ramp_db;
  logic               pwr_q, und_q;
  logic               full, empty, push, pop, flush, set_und, ramp_active;

  function automatic logic [DATA_W-1:0] to_obin(input logic [DATA_W-1:0] x);
    return {~x[DATA_W-1], x[DATA_W-2:0]};
  endfunction

  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign rd_dat     = mem[rd_ptr_q[FIFO_AW-1:0]];

  assign s.s_ready  = enable && (state_q != ST_OFF) && !full;
  assign push       = s.s_valid && s.s_ready;
  // Ramp mode owns the output path, so the FIFO is left untouched.
  assign pop        = enable && (state_q == ST_RUN) && !ramp_active && !empty;

  assign da_data    = da_q;
  assign db_data    = db_q;
  assign pwr        = pwr_q;
  assign running    = (state_q == ST_RUN);
  assign underrun   = und_q;

`ifdef DAC_RAMP_TEST_EN
  logic [DATA_W-1:0] ramp_q;

  assign ramp_active = (state_q == ST_RUN) && test_mode;
  assign ramp_da     = ramp_q;
  assign ramp_db     = ~ramp_q;

  always_ff @(posedge da_clk or posedge reset) begin
    if (reset) begin
      ramp_q <= '0;
    end else if (state_nxt != ST_RUN) begin
      ramp_q <= '0;
    end else if (ramp_active) begin
      ramp_q <= ramp_q + {{(DATA_W-1){1'b0}}, 1'b1};
    end
  end
`else
  logic unused_test_mode;

  assign unused_test_mode = test_mode;
  assign ramp_active      = 1'b0;
  assign ramp_da          = MID;
  assign ramp_db          = MID;
`endif

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    da_nxt    = MID;
    db_nxt    = MID;
    set_und   = 1'b0;
    flush     = 1'b0;
    if (!enable) begin
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
      flush     = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_nxt = ST_PWRUP;
          cnt_nxt   = '0;
          flush     = 1'b1;
        end
        ST_PWRUP: begin
          if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
            state_nxt = ST_PRIME;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        ST_PRIME: begin
          if (fifo_level >= PTR_W'(PRIME_LEVEL)) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (ramp_active) begin
            da_nxt = ramp_da;
            db_nxt = ramp_db;
          end else if (!empty) begin
            da_nxt = to_obin(rd_dat[2*DATA_W-1:DATA_W]);
            db_nxt = to_obin(rd_dat[DATA_W-1:0]);
          end else begin
            // Starved: park at mid-scale and wait for the FIFO to re-prime.
            set_und   = 1'b1;
            state_nxt = ST_PRIME;
          end
        end
        default: begin
          state_nxt = ST_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge da_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      da_q     <= MID;
      db_q     <= MID;
      pwr_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      da_q    <= da_nxt;
      db_q    <= db_nxt;
      pwr_q   <= (state_nxt != ST_OFF);
      // A new starvation event outranks a simultaneous clear.
      und_q   <= set_und | (und_q & ~clr_status);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(push);
        rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      end
    end
  end

  always_ff @(posedge da_clk) begin
    if (push) begin
      mem[wr_ptr_q[FIFO_AW-1:0]] <= {s.s_data_a, s.s_data_b};
    end
  end

endmodule
